// File: rtl/ysyx_22040088_fetch.sv
// rtl/ysyx_22040088_fetch.sv - multi-cycle instruction fetch stage with redirect and kill handling
// Optional misaligned-PC fault: define YSYX_22040088_FETCH_ALIGN_CHECK_EN.
module ysyx_22040088_fetch #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [63:0] req_addr,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_data,
  input  logic        rsp_err,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_fault,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic        kill_q, kill_d;
  logic [63:0] out_pc_q, out_pc_d;
  logic [31:0] out_inst_q, out_inst_d;
  logic        out_fault_q, out_fault_d;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    kill_d      = kill_q;
    out_pc_d    = out_pc_q;
    out_inst_d  = out_inst_q;
    out_fault_d = out_fault_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        // A redirect racing an accepted request must kill the in-flight response.
        if (req_ready) begin
          state_d = WAIT;
          kill_d  = redirect_valid;
        end
        if (redirect_valid) pc_d = redirect_pc;
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_d = redirect_pc;
          if (rsp_valid) begin
            state_d = REQ;
            kill_d  = 1'b0;
          end else begin
            kill_d  = 1'b1;
          end
        end else if (rsp_valid) begin
          if (kill_q) begin
            state_d = REQ;
            kill_d  = 1'b0;
          end else begin
            state_d     = HOLD;
            out_pc_d    = pc_q;
            out_inst_d  = rsp_data;
            out_fault_d = rsp_err;
          end
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = REQ;
        end else if (out_ready) begin
          pc_d    = pc_q + 64'd4;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef YSYX_22040088_FETCH_ALIGN_CHECK_EN
    // A misaligned PC never reaches the bus; it is presented as a faulting nop.
    if (state_d == REQ && pc_d[1:0] != 2'b00) begin
      state_d     = HOLD;
      out_pc_d    = pc_d;
      out_inst_d  = 32'h0000_0013;
      out_fault_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      kill_q      <= 1'b0;
      out_pc_q    <= 64'd0;
      out_inst_q  <= 32'd0;
      out_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      kill_q      <= kill_d;
      out_pc_q    <= out_pc_d;
      out_inst_q  <= out_inst_d;
      out_fault_q <= out_fault_d;
    end
  end

  assign req_valid = (state_q == REQ);
  assign req_addr  = {pc_q[63:2], 2'b00};
  assign out_valid = (state_q == HOLD);
  assign out_pc    = out_pc_q;
  assign out_inst  = out_inst_q;
  assign out_fault = out_fault_q;

endmodule

// File: tb/tb_ysyx_22040088_fetch.sv
// tb/tb_ysyx_22040088_fetch.sv - scoreboard bench for the fetch stage
module tb_ysyx_22040088_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [63:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        out_valid, out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic        out_fault;
  logic        redirect_valid;
  logic [63:0] redirect_pc;

  int errors = 0;
  int checks = 0;

  logic [63:0] exp_req[$];
  logic [96:0] exp_out[$];
  logic [63:0] mon_req;
  logic [96:0] mon_out;

  ysyx_22040088_fetch #(.RESET_PC(64'h8000_0000)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_inst(out_inst), .out_fault(out_fault),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every request and decode handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (req_valid && req_ready) begin
        if (exp_req.size() == 0) begin
          checks++; errors++;
          $display("FAIL req_unexpected: got addr %h expected no request", req_addr);
        end else begin
          mon_req = exp_req.pop_front();
          chk("req_addr", req_addr, mon_req);
        end
      end
      if (out_valid && out_ready) begin
        if (exp_out.size() == 0) begin
          checks++; errors++;
          $display("FAIL out_unexpected: got pc %h expected no output", out_pc);
        end else begin
          mon_out = exp_out.pop_front();
          chk("out_pc", out_pc, mon_out[96:33]);
          chk("out_inst", {32'd0, out_inst}, {32'd0, mon_out[32:1]});
          chk("out_fault", {63'd0, out_fault}, {63'd0, mon_out[0]});
        end
      end
    end
  end

  task automatic wait_req();
    int n = 0;
    while (!req_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("req_wait", {63'd0, req_valid}, 64'd1);
  endtask

  task automatic fetch_one(input logic [63:0] pc, input logic [63:0] addr,
                           input logic [31:0] data, input logic err, input int hold,
                           input logic redir, input logic [63:0] rpc, input logic next_req);
    exp_req.push_back(addr);
    exp_out.push_back({pc, data, err});
    wait_req();
    @(posedge clk); #1;
    rsp_valid = 1'b1; rsp_data = data; rsp_err = err;
    @(negedge clk);
    chk("out_valid_early", {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;
    rsp_valid = 1'b0; rsp_data = 32'd0; rsp_err = 1'b0;
    @(negedge clk);
    chk("out_valid_latency", {63'd0, out_valid}, 64'd1);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("hold_valid", {63'd0, out_valid}, 64'd1);
      chk("hold_no_req", {63'd0, req_valid}, 64'd0);
      chk("hold_pc", out_pc, pc);
      chk("hold_inst", {32'd0, out_inst}, {32'd0, data});
    end
    @(posedge clk); #1;
    out_ready = 1'b1; redirect_valid = redir; redirect_pc = rpc;
    @(posedge clk); #1;
    out_ready = 1'b0; redirect_valid = 1'b0;
    chk("req_after_release", {63'd0, req_valid}, {63'd0, next_req});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_ready = 1'b1; rsp_valid = 1'b0; rsp_data = 32'd0; rsp_err = 1'b0;
    out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 64'd0;
    repeat (2) @(negedge clk);
    chk("rst_req_valid", {63'd0, req_valid}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_pc", out_pc, 64'd0);
    chk("rst_out_inst", {32'd0, out_inst}, 64'd0);
    chk("rst_out_fault", {63'd0, out_fault}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_no_req", {63'd0, req_valid}, 64'd0);

    fetch_one(64'h8000_0000, 64'h8000_0000, 32'h0000_0413, 1'b0, 0, 1'b0, 64'd0, 1'b1);
    fetch_one(64'h8000_0004, 64'h8000_0004, 32'h0010_0093, 1'b0, 5, 1'b0, 64'd0, 1'b1);
    fetch_one(64'h8000_0008, 64'h8000_0008, 32'h1234_5678, 1'b1, 0, 1'b0, 64'd0, 1'b1);

    // Redirect while waiting; stale response three cycles later is dropped.
    exp_req.push_back(64'h8000_000C);
    wait_req();
    @(posedge clk); #1;
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0100;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("stale_no_out", {63'd0, out_valid}, 64'd0);
      @(posedge clk); #1;
    end
    rsp_valid = 1'b1; rsp_data = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("stale_no_out", {63'd0, out_valid}, 64'd0);
    @(posedge clk); #1;
    rsp_valid = 1'b0; rsp_data = 32'd0;
    req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h8000_0180;
    @(negedge clk);
    chk("stale_no_out", {63'd0, out_valid}, 64'd0);
    chk("redirect_addr", req_addr, 64'h8000_0100);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("req_redirect_valid", {63'd0, req_valid}, 64'd1);
    chk("req_redirect_addr", req_addr, 64'h8000_0180);
    @(posedge clk); #1;
    req_ready = 1'b1;

    fetch_one(64'h8000_0180, 64'h8000_0180, 32'h0020_0113, 1'b0, 0, 1'b0, 64'd0, 1'b1);
    fetch_one(64'h8000_0184, 64'h8000_0184, 32'h0030_0193, 1'b0, 0, 1'b1, 64'h8000_0200, 1'b1);
`ifdef YSYX_22040088_FETCH_ALIGN_CHECK_EN
    fetch_one(64'h8000_0200, 64'h8000_0200, 32'h0040_0213, 1'b0, 0, 1'b1, 64'h8000_0102, 1'b0);
    @(negedge clk);
    chk("misalign_valid", {63'd0, out_valid}, 64'd1);
    chk("misalign_no_req", {63'd0, req_valid}, 64'd0);
    exp_out.push_back({64'h8000_0102, 32'h0000_0013, 1'b1});
    @(posedge clk); #1;
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    @(posedge clk); #1;
    out_ready = 1'b0; redirect_valid = 1'b0;
    chk("misalign_release_req", {63'd0, req_valid}, 64'd1);
`else
    fetch_one(64'h8000_0200, 64'h8000_0200, 32'h0040_0213, 1'b0, 0, 1'b1, 64'h8000_0102, 1'b1);
    fetch_one(64'h8000_0102, 64'h8000_0100, 32'h0050_0293, 1'b0, 0, 1'b1,
              64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
`endif
    fetch_one(64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0060_0313, 1'b0, 0,
              1'b0, 64'd0, 1'b1);
    fetch_one(64'd0, 64'd0, 32'h0070_0393, 1'b0, 0, 1'b0, 64'd0, 1'b1);
    req_ready = 1'b0;
    @(negedge clk);
    chk("wrap_next_addr", req_addr, 64'd4);
    repeat (3) @(negedge clk);
    chk("req_queue_drained", 64'(exp_req.size()), 64'd0);
    chk("out_queue_drained", 64'(exp_out.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
